clk_div_cfg_ctrl: RTL

Configuration controller for the frequency/duty divider. It sits between the divider's `i_div_count`, `i_duty_count` and `i_enable` inputs and two software/hardware requesters. Requests are arbitrated round-robin and validated. Each accepted request is applied with a glitch-safe sequence: disable the divider, wait a settle period, load the new counts, re-enable. The winner is acknowledged with a one-cycle pulse.

---
 rtl/clk_div_cfg_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/clk_div_cfg_ctrl.sv
// ============================================================================
//  Module   : clk_div_cfg_ctrl
//  Purpose  : Round-robin, validated, glitch-safe reconfiguration of the
//             frequency/duty divider (disable, settle, load, re-enable).
//  Options  : CLK_DIV_CTRL_SAME_SKIP_EN - commit no-change requests directly.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_cfg_ctrl #(
    parameter int Count_bits    = 16,
    parameter int Settle_cycles = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [1:0]            i_req,
    input  logic [Count_bits-1:0] i_req0_div,
    input  logic [Count_bits-1:0] i_req1_div,
    input  logic [Count_bits-1:0] i_req0_duty,
    input  logic [Count_bits-1:0] i_req1_duty,
    input  logic                  i_req0_en,
    input  logic                  i_req1_en,
    output logic [1:0]            o_gnt,
    output logic [1:0]            o_err,
    output logic [Count_bits-1:0] o_div_count,
    output logic [Count_bits-1:0] o_duty_count,
    output logic                  o_enable,
    output logic                  o_busy
);

    localparam int                    c_settle_w    = $clog2(Settle_cycles + 1);
    localparam logic [c_settle_w-1:0] c_settle_last = c_settle_w'(Settle_cycles - 1);
    localparam logic [c_settle_w-1:0] c_settle_one  = c_settle_w'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        DRAIN  = 3'd2,
        LOAD   = 3'd3,
        COMMIT = 3'd4
    } state_t;

    state_t                  r_state;
    logic                    r_ptr;
    logic                    r_win;
    logic [Count_bits-1:0]   r_div;
    logic [Count_bits-1:0]   r_duty;
    logic                    r_en;
    logic [c_settle_w-1:0]   r_settle;

    logic                    w_win;
    logic                    w_invalid;
    logic                    w_same;

    // r_ptr names the requester that wins when both are asserting.
    assign w_win     = (i_req == 2'b11) ? r_ptr : i_req[1];
    assign w_invalid = r_en && ((r_div == '0) || (r_duty >= r_div));

`ifdef CLK_DIV_CTRL_SAME_SKIP_EN
    assign w_same = (r_en == o_enable) &&
                    (!r_en || ((r_div == o_div_count) && (r_duty == o_duty_count)));
`else
    assign w_same = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state      <= IDLE;
            r_ptr        <= 1'b0;
            r_win        <= 1'b0;
            r_div        <= '0;
            r_duty       <= '0;
            r_en         <= 1'b0;
            r_settle     <= '0;
            o_gnt        <= '0;
            o_err        <= '0;
            o_div_count  <= '0;
            o_duty_count <= '0;
            o_enable     <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            o_gnt <= '0;
            o_err <= '0;
            case (r_state)
                IDLE: begin
                    if (|i_req) begin
                        r_win   <= w_win;
                        r_div   <= w_win ? i_req1_div  : i_req0_div;
                        r_duty  <= w_win ? i_req1_duty : i_req0_duty;
                        r_en    <= w_win ? i_req1_en   : i_req0_en;
                        r_state <= CHECK;
                        o_busy  <= 1'b1;
                    end
                end
                CHECK: begin
                    if (w_invalid) begin
                        o_err   <= {r_win, ~r_win};
                        r_ptr   <= ~r_win;
                        r_state <= IDLE;
                        o_busy  <= 1'b0;
                    end else if (w_same) begin
                        r_state <= COMMIT;
                    end else if (o_enable) begin
                        o_enable <= 1'b0;
                        r_settle <= '0;
                        r_state  <= DRAIN;
                    end else begin
                        r_state <= LOAD;
                    end
                end
                DRAIN: begin
                    if (r_settle == c_settle_last) begin
                        r_state <= LOAD;
                    end else begin
                        r_settle <= r_settle + c_settle_one;
                    end
                end
                LOAD: begin
                    // A disable request keeps the previous counts.
                    if (r_en) begin
                        o_div_count  <= r_div;
                        o_duty_count <= r_duty;
                    end
                    r_state <= COMMIT;
                end
                COMMIT: begin
                    o_enable <= r_en;
                    o_gnt    <= {r_win, ~r_win};
                    r_ptr    <= ~r_win;
                    r_state  <= IDLE;
                    o_busy   <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
